mem_reg_sb: RTL and testbench

Parametrised successor to the single-write-port register file, for the pipelined RiSC-16 core.
- N asynchronous read ports, two write ports (ALU writeback and load writeback), and optional same-cycle write-to-read bypass.
- A per-register pending scoreboard lets decode stall on in-flight producers.
- r0 is hardwired to zero, is never pending, and ignores writes.

---
 rtl/mem_reg_sb.sv | 110 +++++++++++
 tb/tb_mem_reg_sb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reg_sb.sv
// ---------------------------------------------------------------------------
// mem_reg_sb: register file with a pending-producer scoreboard for the
// pipelined RiSC-16 core.
//
// Ports:
//   i_clk, i_rst       clock (posedge) and asynchronous active-high reset
//   i_src              p_READ_PORTS packed read addresses
//   o_src_data         p_READ_PORTS packed read data (combinational)
//   o_src_busy         per read port: source pending and not bypassed
//   i_wr0_*            write port 0 (ALU writeback)
//   i_wr1_*            write port 1 (load writeback), wins over port 0
//   i_iss_en/_tgt      mark a register pending at the next posedge
//   o_pending          scoreboard vector, bit 0 always 0
//
// r0 reads as zero, is never pending and ignores writes. Addresses at or
// above p_REG_FILE_SIZE behave like r0.
// ---------------------------------------------------------------------------
module mem_reg_sb #(
    parameter int unsigned p_WORD_LEN      = 16,
    parameter int unsigned p_REG_ADDR_LEN  = 3,
    parameter int unsigned p_REG_FILE_SIZE = 8,
    parameter int unsigned p_READ_PORTS    = 2,
    parameter int unsigned p_BYPASS        = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [p_READ_PORTS*p_REG_ADDR_LEN-1:0] i_src,
    output logic [p_READ_PORTS*p_WORD_LEN-1:0]     o_src_data,
    output logic [p_READ_PORTS-1:0]                o_src_busy,
    input  logic                                   i_wr0_en,
    input  logic [p_REG_ADDR_LEN-1:0]              i_wr0_tgt,
    input  logic [p_WORD_LEN-1:0]                  i_wr0_data,
    input  logic                                   i_wr1_en,
    input  logic [p_REG_ADDR_LEN-1:0]              i_wr1_tgt,
    input  logic [p_WORD_LEN-1:0]                  i_wr1_data,
    input  logic                                   i_iss_en,
    input  logic [p_REG_ADDR_LEN-1:0]              i_iss_tgt,
    output logic [p_REG_FILE_SIZE-1:0]             o_pending
);

    logic [p_WORD_LEN-1:0]      regs_q [p_REG_FILE_SIZE];
    logic [p_REG_FILE_SIZE-1:0] pending_q;

    // One-hot decodes of each port's target; bit 0 is never set, so r0 and
    // out-of-range targets fall out naturally. Reset masks all of them so
    // that the bypass path also shows the cleared state during reset.
    logic [p_REG_FILE_SIZE-1:0] wr0_hit;
    logic [p_REG_FILE_SIZE-1:0] wr1_hit;
    logic [p_REG_FILE_SIZE-1:0] iss_hit;

    always_comb begin
        wr0_hit = '0;
        wr1_hit = '0;
        iss_hit = '0;
        for (int r = 1; r < int'(p_REG_FILE_SIZE); r++) begin
            wr0_hit[r] = ~i_rst & i_wr0_en & (i_wr0_tgt == p_REG_ADDR_LEN'(r));
            wr1_hit[r] = ~i_rst & i_wr1_en & (i_wr1_tgt == p_REG_ADDR_LEN'(r));
            iss_hit[r] = ~i_rst & i_iss_en & (i_iss_tgt == p_REG_ADDR_LEN'(r));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < int'(p_REG_FILE_SIZE); r++) begin
                regs_q[r] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int r = 1; r < int'(p_REG_FILE_SIZE); r++) begin
                if (wr1_hit[r]) begin
                    regs_q[r] <= i_wr1_data;
                end else if (wr0_hit[r]) begin
                    regs_q[r] <= i_wr0_data;
                end

                // A new issue supersedes the producer retiring this cycle.
                if (iss_hit[r]) begin
                    pending_q[r] <= 1'b1;
                end else if (wr0_hit[r] | wr1_hit[r]) begin
                    pending_q[r] <= 1'b0;
                end
            end
            pending_q[0] <= 1'b0;
        end
    end

    assign o_pending = pending_q;

    // Reads: address decode by comparison so that out-of-range addresses
    // never index the array and simply return zero.
    always_comb begin
        o_src_data = '0;
        o_src_busy = '0;
        for (int k = 0; k < int'(p_READ_PORTS); k++) begin
            for (int r = 1; r < int'(p_REG_FILE_SIZE); r++) begin
                if (i_src[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN] == p_REG_ADDR_LEN'(r)) begin
                    if ((p_BYPASS != 0) && (wr0_hit[r] | wr1_hit[r])) begin
                        o_src_data[k*p_WORD_LEN +: p_WORD_LEN] =
                            wr1_hit[r] ? i_wr1_data : i_wr0_data;
                        o_src_busy[k] = 1'b0;
                    end else begin
                        o_src_data[k*p_WORD_LEN +: p_WORD_LEN] = regs_q[r];
                        o_src_busy[k] = pending_q[r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_reg_sb.sv
// ---------------------------------------------------------------------------
// tb_mem_reg_sb: two instances driven in parallel,
//   dut_a: 8 registers, bypass on
//   dut_b: 6 registers, bypass off (addresses 6 and 7 are out of range)
// A behavioural model (plain arrays) predicts every output; a negedge
// process compares both instances each cycle. Directed steps add literal
// expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_mem_reg_sb;

    logic        clk;
    logic        rst;
    logic [2:0]  src0, src1;
    logic        wr0_en, wr1_en, iss_en;
    logic [2:0]  wr0_tgt, wr1_tgt, iss_tgt;
    logic [15:0] wr0_data, wr1_data;

    logic [31:0] a_data;
    logic [1:0]  a_busy;
    logic [7:0]  a_pend;
    logic [31:0] b_data;
    logic [1:0]  b_busy;
    logic [5:0]  b_pend;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_on = 0;

    mem_reg_sb #(
        .p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(8),
        .p_READ_PORTS(2), .p_BYPASS(1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_src({src1, src0}),
        .o_src_data(a_data), .o_src_busy(a_busy),
        .i_wr0_en(wr0_en), .i_wr0_tgt(wr0_tgt), .i_wr0_data(wr0_data),
        .i_wr1_en(wr1_en), .i_wr1_tgt(wr1_tgt), .i_wr1_data(wr1_data),
        .i_iss_en(iss_en), .i_iss_tgt(iss_tgt), .o_pending(a_pend)
    );

    mem_reg_sb #(
        .p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(6),
        .p_READ_PORTS(2), .p_BYPASS(0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_src({src1, src0}),
        .o_src_data(b_data), .o_src_busy(b_busy),
        .i_wr0_en(wr0_en), .i_wr0_tgt(wr0_tgt), .i_wr0_data(wr0_data),
        .i_wr1_en(wr1_en), .i_wr1_tgt(wr1_tgt), .i_wr1_data(wr1_data),
        .i_iss_en(iss_en), .i_iss_tgt(iss_tgt), .o_pending(b_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [15:0] mregs [2][8];
    logic [7:0]  mpend [2];

    function automatic int sz(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    function automatic bit byp(input int i);
        return (i == 0);
    endfunction

    function automatic bit wvalid(input int i, input logic en, input logic [2:0] t);
        return en && !rst && (t != 3'd0) && (int'(t) < sz(i));
    endfunction

    function automatic logic [15:0] exp_rd(input int i, input logic [2:0] a);
        if (a == 3'd0 || int'(a) >= sz(i)) return 16'h0000;
        if (byp(i) && wvalid(i, wr1_en, wr1_tgt) && wr1_tgt == a) return wr1_data;
        if (byp(i) && wvalid(i, wr0_en, wr0_tgt) && wr0_tgt == a) return wr0_data;
        return mregs[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [2:0] a);
        bit wr_here;
        if (a == 3'd0 || int'(a) >= sz(i)) return 1'b0;
        wr_here = (wvalid(i, wr0_en, wr0_tgt) && wr0_tgt == a) ||
                  (wvalid(i, wr1_en, wr1_tgt) && wr1_tgt == a);
        return mpend[i][a] && !(byp(i) && wr_here);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mpend[i] = 8'h00;
                for (int r = 0; r < 8; r++) mregs[i][r] = 16'h0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wvalid(i, wr0_en, wr0_tgt)) begin
                    mregs[i][wr0_tgt] = wr0_data;
                    mpend[i][wr0_tgt] = 1'b0;
                end
                if (wvalid(i, wr1_en, wr1_tgt)) begin
                    mregs[i][wr1_tgt] = wr1_data;
                    mpend[i][wr1_tgt] = 1'b0;
                end
                if (wvalid(i, iss_en, iss_tgt)) mpend[i][iss_tgt] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [31:0] e_data;
    logic [1:0]  e_busy;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                e_data = {exp_rd(i, src1), exp_rd(i, src0)};
                e_busy = {exp_busy(i, src1), exp_busy(i, src0)};
                if (i == 0) begin
                    chk("a_src_data", a_data, e_data);
                    chk("a_src_busy", {30'd0, a_busy}, {30'd0, e_busy});
                    chk("a_pending", {24'd0, a_pend}, {24'd0, mpend[0]});
                end else begin
                    chk("b_src_data", b_data, e_data);
                    chk("b_src_busy", {30'd0, b_busy}, {30'd0, e_busy});
                    chk("b_pending", {26'd0, b_pend}, {24'd0, mpend[1]});
                end
            end
        end
    end

    // Applies one cycle of inputs just after the posedge.
    task automatic drive(input logic w0e, input logic [2:0] w0t, input logic [15:0] w0d,
                         input logic w1e, input logic [2:0] w1t, input logic [15:0] w1d,
                         input logic ie, input logic [2:0] it,
                         input logic [2:0] s0, input logic [2:0] s1);
        @(posedge clk);
        #1;
        wr0_en = w0e; wr0_tgt = w0t; wr0_data = w0d;
        wr1_en = w1e; wr1_tgt = w1t; wr1_data = w1d;
        iss_en = ie;  iss_tgt = it;
        src0 = s0;    src1 = s1;
    endtask

    task automatic idle(input logic [2:0] s0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, s0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        wr0_en = 0; wr0_tgt = 0; wr0_data = 0;
        wr1_en = 0; wr1_tgt = 0; wr1_data = 0;
        iss_en = 0; iss_tgt = 0; src0 = 0; src1 = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_pend_a", {24'd0, a_pend}, 32'h0);
        chk("reset_data_a", a_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;

        drive(1, 3, 16'h1234, 0, 0, 0, 0, 0, 3, 0);
        #2;
        chk("byp_r3_a", {16'd0, a_data[15:0]}, 32'h1234);
        chk("nobyp_r3_b", {16'd0, b_data[15:0]}, 32'h0000);

        drive(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 3, 0);
        #2;
        chk("rd_r3_a", {16'd0, a_data[15:0]}, 32'h1234);
        chk("rd_r3_b", {16'd0, b_data[15:0]}, 32'h1234);
        chk("rd_r0_a", {16'd0, a_data[31:16]}, 32'h0000);

        drive(1, 5, 16'h1111, 1, 5, 16'h2222, 0, 0, 5, 0);
        #2;
        chk("coll_byp_a", {16'd0, a_data[15:0]}, 32'h2222);
        chk("coll_nobyp_b", {16'd0, b_data[15:0]}, 32'h0000);

        drive(1, 2, 16'h00AA, 0, 0, 0, 0, 0, 5, 0);
        #2;
        chk("coll_r5_a", {16'd0, a_data[15:0]}, 32'h2222);
        chk("coll_r5_b", {16'd0, b_data[15:0]}, 32'h2222);

        drive(1, 2, 16'h00BB, 0, 0, 0, 0, 0, 2, 0);
        #2;
        chk("r2_byp_a", {16'd0, a_data[15:0]}, 32'h00BB);
        chk("r2_nobyp_b", {16'd0, b_data[15:0]}, 32'h00AA);

        drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        idle(4);
        #2;
        chk("iss_pend4_a", {31'd0, a_pend[4]}, 32'h1);
        chk("iss_pend4_b", {31'd0, b_pend[4]}, 32'h1);
        chk("iss_busy_a", {31'd0, a_busy[0]}, 32'h1);
        chk("iss_busy_b", {31'd0, b_busy[0]}, 32'h1);

        drive(0, 0, 0, 1, 4, 16'h0042, 0, 0, 4, 0);
        #2;
        chk("wb_busy_a", {31'd0, a_busy[0]}, 32'h0);
        chk("wb_busy_b", {31'd0, b_busy[0]}, 32'h1);
        chk("wb_data_b", {16'd0, b_data[15:0]}, 32'h0000);

        idle(4);
        #2;
        chk("wb_pend4_a", {31'd0, a_pend[4]}, 32'h0);
        chk("wb_pend4_b", {31'd0, b_pend[4]}, 32'h0);
        chk("wb_r4_b", {16'd0, b_data[15:0]}, 32'h0042);

        drive(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
        drive(1, 6, 16'h0007, 0, 0, 0, 1, 6, 6, 0);
        #2;
        chk("r6_pend_a", {24'd0, a_pend}, 32'h40);
        chk("r6_oor_pend_b", {26'd0, b_pend}, 32'h0);
        chk("r6_oor_data_b", {16'd0, b_data[15:0]}, 32'h0000);

        drive(0, 0, 0, 0, 0, 0, 1, 0, 6, 0);
        #2;
        chk("iss_win_a", {24'd0, a_pend}, 32'h40);
        chk("iss_win_data_a", {16'd0, a_data[15:0]}, 32'h0007);

        idle(0);
        #2;
        chk("iss_r0_a", {24'd0, a_pend}, 32'h40);

        for (int r = 1; r < 8; r++) begin
            drive(1, 3'(r), 16'h1000 + 16'(r), 0, 0, 0, (r == 7), 2, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 1);
        #2;
        chk("pre_rst_a", a_data, 32'h1001_1007);
        chk("pre_rst_b", b_data, 32'h1001_0000);
        chk("pre_rst_pend_a", {24'd0, a_pend}, 32'h04);
        chk("pre_rst_pend_b", {26'd0, b_pend}, 32'h04);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_data_a", a_data, 32'h0);
        chk("mid_rst_data_b", b_data, 32'h0);
        chk("mid_rst_pend_a", {24'd0, a_pend}, 32'h0);
        chk("mid_rst_pend_b", {26'd0, b_pend}, 32'h0);
        // Writes and issues while held in reset must be ignored.
        drive(1, 3, 16'hBEEF, 1, 5, 16'hCAFE, 1, 3, 3, 5);
        #2;
        chk("rst_hold_data_a", a_data, 32'h0);
        chk("rst_hold_pend_a", {24'd0, a_pend}, 32'h0);
        idle(3);
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), 16'($urandom()),
                  $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 16'($urandom()),
                  $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0;
        repeat (3) idle(0);
        @(posedge clk);
        #1;
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
